ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Data-memory responder: the target end of the CPU's RAM interface.
- Services the CPU's ram_read/ram_write requests with a 4-phase ready handshake.
- Holds a 2^ADDR_W x DATA_W storage array and applies a programmable wait-state latency.
- Sits between the CPU datapath and data storage. Its outputs feed the CPU's ram_data_in.

Parameters:
ADDR_W, 6, address width; memory depth is 2^ADDR_W words.
DATA_W, 16, word width.
WAIT_CYCLES, 2, wait states inserted before the access cycle; legal range 0..15.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
ram_read  input  1  read request, level, held until ram_ready.
ram_write  input  1  write request, level, held until ram_ready.
ram_addr  input  ADDR_W  request word address.
ram_data_out  input  DATA_W  write data from CPU.
ram_data_in  output  DATA_W  read data to CPU.
ram_ready  output  1  response valid / request complete.
ram_error  output  1  illegal request (read and write both high).
busy  output  1  high in WAIT and ACCESS.
resp_state  output  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ram_ready=0, ram_error=0, busy=0, ram_data_in=0, wait counter=0.
  - Storage array is NOT cleared.
  - A write aborted before its ACCESS-exit edge is never committed.
- State encoding: IDLE=00, WAIT=01, ACCESS=10, RESP=11.
- IDLE:
  - Exactly one of ram_read/ram_write high at a rising edge: latch ram_addr, ram_data_out and op.
  - Then go to WAIT with counter=WAIT_CYCLES, or to ACCESS if WAIT_CYCLES==0.
  - Both high: no latch, no access. Go to RESP with ram_error=1.
  - Neither high: stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - Leaves to ACCESS on the edge where counter==1. WAIT therefore lasts exactly WAIT_CYCLES cycles.
  - ram_addr and ram_data_out changes are ignored; latched values are used.
- ACCESS (one cycle), on its exit edge:
  - Write: mem[latched_addr] <= latched_wdata.
  - Read: ram_data_in <= mem[latched_addr].
  - Then go to RESP.
- RESP:
  - ram_ready=1.
  - Stays in RESP while ram_read or ram_write is high (4-phase handshake).
  - Returns to IDLE on the first edge where both are low. ram_ready and ram_error clear on that edge.
  - Requests seen while in RESP are never treated as new requests.
- Latency: request sampled at edge N gives ram_ready=1 after edge N+WAIT_CYCLES+1.
  - Minimum back-to-back spacing: requester drops the request for one cycle, then re-asserts.
- ram_data_in:
  - Changes only on a read's ACCESS-exit edge or on reset.
  - Holds its value through writes, error responses and IDLE.
- ram_error: high only in a RESP entered from an illegal request.
- busy: high exactly when state is WAIT or ACCESS.
- Address space is full-decode (2^ADDR_W words); no out-of-range case exists.
- Reset asserted mid-WAIT or mid-ACCESS: immediate return to IDLE, no commit, ram_ready=0.

Test Plan:
- Reset → outputs: reset=0 with random inputs → ram_ready=0, ram_error=0, busy=0, ram_data_in=0, resp_state=00.
- Write then read, WAIT_CYCLES=2:
  - Write 0xBEEF to addr 0x05; ram_ready rises 3 cycles after the request edge; drop the request.
  - Read addr 0x05 → ram_data_in=0xBEEF when ram_ready=1.
  - busy high for exactly 3 cycles per request.
- Handshake hold: hold ram_read high 5 cycles after ram_ready → ram_ready stays 1, state stays 11, no second access.
  - Drop ram_read → IDLE next edge.
- Illegal request: ram_read=ram_write=1 at addr 0x05 → next cycle ram_ready=1, ram_error=1, mem[0x05] still 0xBEEF, ram_data_in unchanged.
- Reset mid-write: write 0x1234 to addr 0x3F; assert reset during WAIT → no commit; read 0x3F returns its prior value (0xAAAA preloaded).
- WAIT_CYCLES=0 build: write 0x00FF to addr 0x00 → ram_ready after edge N+1; address change during request ignored; read back 0x00FF.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: target end of the CPU data-memory interface.
// Services ram_read / ram_write requests from a 2^ADDR_W x DATA_W storage array.
// It inserts WAIT_CYCLES wait states, then one access cycle, and then a
// 4-phase ready response.
//
// Ports:
//   clk           rising-edge system clock
//   reset         asynchronous active-low reset
//   ram_read      read request (level, held until ram_ready)
//   ram_write     write request (level, held until ram_ready)
//   ram_addr      request word address
//   ram_data_out  write data from the CPU
//   ram_data_in   read data to the CPU
//   ram_ready     response valid / request complete
//   ram_error     illegal request (read and write both high)
//   busy          high while in WAIT or ACCESS
//   resp_state    current FSM state (debug)
module ram_responder #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_ready,
  output logic              ram_error,
  output logic              busy,
  output logic [1:0]        resp_state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWait   = 2'b01,
    StAccess = 2'b10,
    StResp   = 2'b11
  } state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e state_q, state_d;

  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic legal_req;
  logic illegal_req;
  logic any_req;

  assign legal_req   = ram_read ^ ram_write;
  assign illegal_req = ram_read & ram_write;
  assign any_req     = ram_read | ram_write;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (illegal_req) begin
          state_d = StResp;
        end else if (legal_req) begin
          state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
        end
      end
      // Counter was loaded with WAIT_CYCLES, so WAIT spans exactly that many cycles.
      StWait:   if (cnt_q == 4'd1) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (!any_req) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    ram_ready   = (state_q == StResp);
    ram_error   = (state_q == StResp) && err_q;
    busy        = (state_q == StWait) || (state_q == StAccess);
    resp_state  = state_q;
    ram_data_in = rdata_q;
  end

  // Request latch, wait counter, error flag and read-data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (legal_req) begin
            addr_q  <= ram_addr;
            wdata_q <= ram_data_out;
            we_q    <= ram_write;
            err_q   <= 1'b0;
            cnt_q   <= WaitInit;
          end else if (illegal_req) begin
            err_q <= 1'b1;
          end
        end
        StWait:   cnt_q <= cnt_q - 4'd1;
        StAccess: if (!we_q) rdata_q <= mem_q[addr_q];
        StResp:   if (!any_req) err_q <= 1'b0;
        default:  ;
      endcase
    end
  end

  // A reset during WAIT/ACCESS forces state_q to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && we_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=2 instance, index 1: WAIT_CYCLES=0 instance.
  logic        rd    [2];
  logic        wr    [2];
  logic [5:0]  addr  [2];
  logic [15:0] wd    [2];
  logic [15:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        bsy   [2];
  logic [1:0]  st    [2];

  int n_checks = 0;
  int n_fail   = 0;

  ram_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .ram_read(rd[0]), .ram_write(wr[0]), .ram_addr(addr[0]),
    .ram_data_out(wd[0]), .ram_data_in(rdata[0]), .ram_ready(rdy[0]), .ram_error(err[0]),
    .busy(bsy[0]), .resp_state(st[0])
  );

  ram_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .ram_read(rd[1]), .ram_write(wr[1]), .ram_addr(addr[1]),
    .ram_data_out(wd[1]), .ram_data_in(rdata[1]), .ram_ready(rdy[1]), .ram_error(err[1]),
    .busy(bsy[1]), .resp_state(st[1])
  );

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: m_k counts edges since a request was accepted.
  // k in 1..W is waiting, k == W+1 is the access cycle, k == W+2 is responding.
  bit          m_on  [2];
  int          m_k   [2];
  bit          m_err [2];
  bit          m_we  [2];
  logic [5:0]  m_a   [2];
  logic [15:0] m_wd  [2];
  logic [15:0] m_rd  [2];
  logic [15:0] m_mem [2][64];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_on[i]  <= 1'b0;
        m_k[i]   <= 0;
        m_err[i] <= 1'b0;
        m_rd[i]  <= 16'h0;
      end else if (!m_on[i]) begin
        if (rd[i] != wr[i]) begin
          m_on[i]  <= 1'b1;
          m_err[i] <= 1'b0;
          m_k[i]   <= 1;
          m_a[i]   <= addr[i];
          m_wd[i]  <= wd[i];
          m_we[i]  <= wr[i];
        end else if (rd[i] && wr[i]) begin
          m_on[i]  <= 1'b1;
          m_err[i] <= 1'b1;
          m_k[i]   <= wc(i) + 2;
        end
      end else if (m_k[i] < wc(i) + 2) begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] + 1 == wc(i) + 2) begin
          if (m_we[i]) m_mem[i][m_a[i]] <= m_wd[i];
          else         m_rd[i] <= m_mem[i][m_a[i]];
        end
      end else if (!rd[i] && !wr[i]) begin
        m_on[i] <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < 2; i++) begin
        logic       e_rdy;
        logic       e_busy;
        logic [1:0] e_st;
        e_rdy  = m_on[i] && (m_k[i] == wc(i) + 2);
        e_busy = m_on[i] && (m_k[i] <= wc(i) + 1);
        e_st   = !m_on[i] ? 2'd0 : (m_k[i] <= wc(i)) ? 2'd1 :
                 (m_k[i] == wc(i) + 1) ? 2'd2 : 2'd3;
        chk($sformatf("dut%0d.ram_ready", i), 32'(rdy[i]), 32'(e_rdy));
        chk($sformatf("dut%0d.ram_error", i), 32'(err[i]), 32'(e_rdy && m_err[i]));
        chk($sformatf("dut%0d.busy", i), 32'(bsy[i]), 32'(e_busy));
        chk($sformatf("dut%0d.resp_state", i), 32'(st[i]), 32'(e_st));
        chk($sformatf("dut%0d.ram_data_in", i), 32'(rdata[i]), 32'(m_rd[i]));
      end
    end
  end

  // One request from issue to release; returns latency (edges after the request edge
  // until ram_ready), busy cycles seen, and read data / error while ready.
  task automatic xact(input int i, input bit r, input bit w, input logic [5:0] a,
                      input logic [15:0] d, input int hold, output int lat, output int bcnt,
                      output logic [15:0] dat, output bit e);
    int hb;
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
    @(posedge clk); #3;
    lat = 0; bcnt = 0;
    if (!rdy[i]) begin
      // Address/data changes after acceptance must be ignored.
      @(negedge clk);
      addr[i] = ~a; wd[i] = ~d;
    end
    while (!rdy[i] && lat < 50) begin
      bcnt += int'(bsy[i]);
      @(posedge clk); #3;
      lat++;
    end
    if (lat >= 50) chk("ready_timeout", 32'(lat), 32'd0);
    dat = rdata[i];
    e   = err[i];
    hb  = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #3;
      hb += int'(bsy[i]);
      chk("hold_ready", 32'(rdy[i]), 32'd1);
    end
    if (hold > 0) begin
      chk("hold_busy_cycles", 32'(hb), 32'd0);
      chk("hold_state", 32'(st[i]), 32'd3);
    end
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(posedge clk); #3;
    chk("release_state", 32'(st[i]), 32'd0);
    chk("release_ready", 32'(rdy[i]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          bc;
    logic [15:0] dat;
    bit          e;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    #1 reset = 1'b0;

    // Reset with random inputs.
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rd[i] = 1'($urandom); wr[i] = 1'($urandom);
        addr[i] = 6'($urandom); wd[i] = 16'($urandom);
      end
      @(posedge clk); #3;
      chk("rst_ready", 32'(rdy[0]), 32'd0);
      chk("rst_error", 32'(err[0]), 32'd0);
      chk("rst_busy", 32'(bsy[0]), 32'd0);
      chk("rst_data", 32'(rdata[0]), 32'd0);
      chk("rst_state", 32'(st[0]), 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;

    // WAIT_CYCLES=2: write then read.
    xact(0, 1'b0, 1'b1, 6'h05, 16'hBEEF, 0, lat, bc, dat, e);
    chk("w2_write_latency", 32'(lat), 32'd3);
    chk("w2_write_busy", 32'(bc), 32'd3);
    chk("w2_write_data_in_held", 32'(dat), 32'd0);
    xact(0, 1'b1, 1'b0, 6'h05, 16'h0000, 5, lat, bc, dat, e);
    chk("w2_read_latency", 32'(lat), 32'd3);
    chk("w2_read_busy", 32'(bc), 32'd3);
    chk("w2_read_data", 32'(dat), 32'hBEEF);

    // Illegal request.
    xact(0, 1'b1, 1'b1, 6'h05, 16'h5555, 0, lat, bc, dat, e);
    chk("illegal_latency", 32'(lat), 32'd0);
    chk("illegal_error", 32'(e), 32'd1);
    chk("illegal_busy", 32'(bc), 32'd0);
    chk("illegal_data_held", 32'(dat), 32'hBEEF);
    xact(0, 1'b1, 1'b0, 6'h05, 16'h0000, 0, lat, bc, dat, e);
    chk("illegal_no_write", 32'(dat), 32'hBEEF);
    chk("legal_error_clear", 32'(e), 32'd0);

    // Reset during WAIT aborts a write.
    xact(0, 1'b0, 1'b1, 6'h3F, 16'hAAAA, 0, lat, bc, dat, e);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 6'h3F; wd[0] = 16'h1234;
    @(posedge clk); #3;
    chk("abort_in_wait", 32'(st[0]), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_state", 32'(st[0]), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd0);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_data", 32'(rdata[0]), 32'd0);
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    xact(0, 1'b1, 1'b0, 6'h3F, 16'h0000, 0, lat, bc, dat, e);
    chk("abort_no_commit", 32'(dat), 32'hAAAA);

    // WAIT_CYCLES=0 instance.
    xact(1, 1'b0, 1'b1, 6'h00, 16'h00FF, 0, lat, bc, dat, e);
    chk("w0_write_latency", 32'(lat), 32'd1);
    chk("w0_write_busy", 32'(bc), 32'd1);
    xact(1, 1'b1, 1'b0, 6'h00, 16'h0000, 0, lat, bc, dat, e);
    chk("w0_read_latency", 32'(lat), 32'd1);
    chk("w0_read_data", 32'(dat), 32'h00FF);

    repeat (2) @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
